spi_regfile_periph: RTL and testbench
=====================================

// Module: spi_regfile_periph
// PURPOSE
//  Parametrised SPI Mode-0 peripheral with a NUM_REGS x DATA_W register file and framing-error detection.
//  Successor to the fixed 8-bit write-only SPI register block; adds optional read-back on CIPO.
//  Sits between the chip pins and the user datapath; clk is the system clock, all SPI pins are asynchronous.
// PARAMETERS
//  NUM_REGS     5  number of implemented registers (addresses 0..NUM_REGS-1)
//  DATA_W       8  register/data field width, bits
//  ADDR_W       7  address field width; NUM_REGS <= 2**ADDR_W
//  SYNC_STAGES  2  synchroniser depth on ncs/sclk/copi (>=2)
//  ERR_W        8  width of saturating frame-error counter
// PORTS
//  clk        in   1                  system clock
//  rst_n      in   1                  asynchronous, active-low reset
//  ncs        in   1                  SPI chip select, active low, async
//  sclk       in   1                  SPI clock, async, idle low
//  copi       in   1                  controller-out data, async
//  cipo       out  1                  controller-in data (registered)
//  cipo_oe    out  1                  cipo output enable (pad driver)
//  regs_flat  out  NUM_REGS*DATA_W    register file; reg i at [i*DATA_W +: DATA_W]
//  wr_pulse   out  1                  1-cycle strobe when a write commits
//  wr_addr    out  ADDR_W             address of last committed write
//  err_cnt    out  ERR_W              saturating count of rejected frames
// BEHAVIOUR
//  Reset: all outputs 0, including regs_flat, cipo, cipo_oe, wr_pulse, wr_addr, err_cnt.
//  Reset clears the synchronisers to idle: ncs=1, sclk=0.
//  Rising clk edge; sclk/copi/ncs pass through SYNC_STAGES flops plus an edge-detect flop.
//  SCLK high and low times must each be >= SYNC_STAGES+2 clk cycles.
//  Frame: FRAME_W = 1+ADDR_W+DATA_W bits, MSB first, sampled on synced sclk rising edge.
//   Bit 0 is R/W (1=write), then ADDR_W address bits, then DATA_W data bits.
//  FSM: IDLE -> CMD (ncs falling) -> ADDR (after R/W bit) -> DATA (after ADDR_W bits) -> DONE (after DATA_W bits).
//   Any state -> IDLE on synced ncs rising edge.
//   Edges arriving in DONE do not shift; they mark the frame overlength.
//  Commit on synced ncs rising edge:
//   Write commits iff state==DONE, not overlength, R/W=1, and addr<NUM_REGS.
//   Commit: regs[addr]<=data; wr_addr<=addr; wr_pulse=1 on the next cycle.
//   Latency ncs-rise(synced) -> regs_flat update: 1 clk.
//  Rejected frames increment err_cnt (saturates at all-ones, no wrap):
//   short frame (ncs high before DONE, including 0 bits), overlength frame, out-of-range write address.
//  A read (R/W=0) with correct length is never an error.
//  ncs held low with no sclk edges for any time: no state change.
//  ncs glitch shorter than SYNC_STAGES clk cycles: undefined, not required to be filtered.
//  rst_n asserted mid-frame: frame discarded; registers return to 0; no err_cnt increment.
//  A new ncs fall may occur on the cycle after commit; wr_pulse from the old frame is still issued.
// CONFIGURATION
//  SPI_READBACK_EN defined, read frames (R/W=0):
//   On entering DATA, load an out-shifter with regs[addr], or 0 if addr>=NUM_REGS.
//   cipo presents the MSB immediately, then shifts on each synced sclk falling edge.
//   cipo_oe=1 while ncs is low.
//   Write frames drive cipo=0.
//  SPI_READBACK_EN undefined: cipo=0, cipo_oe=0 constantly; read frames are silently accepted; no out-shifter.
// STRUCTURE
//  Package spi_periph_pkg:
//   FRAME_W function of (ADDR_W, DATA_W)
//   FSM state enum {IDLE,CMD,ADDR,DATA,DONE}
//   constants OP_READ=1'b0, OP_WRITE=1'b1
//  Sub-module spi_sync_edge:
//   One per SPI input; SYNC_STAGES synchroniser plus rise/fall pulse outputs.
//   Reset value is a parameter (1 for ncs, 0 otherwise).
//  Top level: FSM, bit counter, in-shifter, register array, error counter, optional out-shifter.
// TESTING
//  Write 0x1_02_A5 (W, addr 2, data 0xA5): regs[2]==0xA5, wr_pulse once, wr_addr==2, err_cnt==0.
//  Write to addr 5 (NUM_REGS=5): no register change, no wr_pulse, err_cnt 0->1.
//  10-bit and 17-bit frames of a write to addr 0: reg 0 unchanged, err_cnt +=2; then a valid frame commits normally.
//  With SPI_READBACK_EN, after writing 0x3C to reg 1, read addr 1: cipo bits in DATA phase == 0x3C; read addr 9 returns 0x00.
//  Without SPI_READBACK_EN, same read: cipo==0, cipo_oe==0 throughout, err_cnt unchanged.
//  Pulse rst_n low after 12 bits of a write, then 257 short frames: regs all 0, err_cnt==0xFF (saturated).

Source files
------------

// File: rtl/spi_periph_pkg.sv
// ============================================================================
// Module  : spi_periph_pkg
// Brief   : Shared types and constants for the SPI register-file peripheral.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package spi_periph_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } spi_state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module  : spi_sync_edge
// Brief   : Multi-flop synchroniser for one asynchronous SPI pin with rise/fall
//           pulses generated from an extra edge-detect flop.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

`default_nettype wire

// File: rtl/spi_regfile_periph.sv
// ============================================================================
// Module  : spi_regfile_periph
// Brief   : SPI Mode-0 peripheral driving a NUM_REGS x DATA_W register file,
//           with frame-error counting. Define SPI_READBACK_EN for CIPO reads.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module spi_regfile_periph
  import spi_periph_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ncs,
  input  logic                       sclk,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [ERR_W-1:0]           err_cnt
);

  localparam int               FRAME_W      = frame_w(ADDR_W, DATA_W);
  localparam int               CNT_W        = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] ADDR_END     = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] DATA_END     = CNT_W'(FRAME_W);
  localparam logic [ADDR_W:0]  NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

  logic ncs_lvl, ncs_rise, ncs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .async_i(ncs),
    .level_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_i(sclk),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .async_i(copi),
    .level_o(copi_lvl), .rise_o(copi_rise), .fall_o(copi_fall)
  );

  spi_state_e                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       rw_q, rw_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [DATA_W-1:0]          data_q, data_d;
  logic                       ovl_q, ovl_d;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic                       wr_pulse_q;
  logic [ADDR_W-1:0]          wr_addr_q;
  logic [ERR_W-1:0]           err_q;

  logic              commit, reject, load_out, good_len, addr_ok;
  logic [CNT_W-1:0]  cnt_inc;
  logic [ADDR_W-1:0] addr_shift;

  assign cnt_inc    = cnt_q + 1'b1;
  assign addr_shift = {addr_q[ADDR_W-2:0], copi_lvl};
  assign good_len   = (state_q == DONE) && !ovl_q;
  assign addr_ok    = {1'b0, addr_q} < NUM_REGS_EXT;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ovl_d    = ovl_q;
    commit   = 1'b0;
    reject   = 1'b0;
    load_out = 1'b0;
    if (ncs_rise) begin
      state_d = IDLE;
      if (state_q != IDLE) begin
        if (good_len && rw_q == OP_WRITE && addr_ok) begin
          commit = 1'b1;
        end else if (!(good_len && rw_q == OP_READ)) begin
          reject = 1'b1;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (ncs_fall) begin
            state_d = CMD;
            cnt_d   = '0;
            rw_d    = OP_READ;
            addr_d  = '0;
            data_d  = '0;
            ovl_d   = 1'b0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            rw_d    = copi_lvl;
            cnt_d   = cnt_inc;
            state_d = ADDR;
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            addr_d = addr_shift;
            cnt_d  = cnt_inc;
            if (cnt_inc == ADDR_END) begin
              state_d  = DATA;
              load_out = 1'b1;
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            data_d = {data_q[DATA_W-2:0], copi_lvl};
            cnt_d  = cnt_inc;
            if (cnt_inc == DATA_END) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          // Extra edges after a full frame only poison it; the payload is kept.
          if (sclk_rise) begin
            ovl_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rw_q       <= OP_READ;
      addr_q     <= '0;
      data_q     <= '0;
      ovl_q      <= 1'b0;
      regs_q     <= '0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ovl_q      <= ovl_d;
      wr_pulse_q <= commit;
      if (commit) begin
        wr_addr_q <= addr_q;
      end
      if (reject && (err_q != {ERR_W{1'b1}})) begin
        err_q <= err_q + 1'b1;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && addr_q == ADDR_W'(i)) begin
          regs_q[i*DATA_W +: DATA_W] <= data_q;
        end
      end
    end
  end

  assign regs_flat = regs_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign err_cnt   = err_q;

  logic unused_pins;
  assign unused_pins = ^{copi_rise, copi_fall, sclk_lvl};

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] rd_data;
  logic              oe_q;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_shift == ADDR_W'(i)) begin
        rd_data = regs_q[i*DATA_W +: DATA_W];
      end
    end
  end

  // The fall right after loading precedes the first data sample, so hold the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      oe_q  <= 1'b0;
    end else begin
      oe_q <= ~ncs_lvl;
      if (ncs_rise || (state_q == IDLE && ncs_fall)) begin
        out_q <= '0;
      end else if (load_out) begin
        out_q <= (rw_q == OP_READ) ? rd_data : '0;
      end else if (sclk_fall && ((state_q == DATA && cnt_q != ADDR_END) || state_q == DONE)) begin
        out_q <= {out_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign cipo    = out_q[DATA_W-1];
  assign cipo_oe = oe_q;
`else
  logic unused_rb;
  assign unused_rb = ^{sclk_fall, ncs_lvl, load_out};
  assign cipo      = 1'b0;
  assign cipo_oe   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_regfile_periph.sv
// ============================================================================
// Module  : tb_spi_regfile_periph
// Brief   : Directed self-checking bench for spi_regfile_periph (both builds).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_spi_regfile_periph;

  localparam int NUM_REGS = 5;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int ERR_W    = 8;
  localparam int HALF     = 6;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       ncs;
  logic                       sclk;
  logic                       copi;
  logic                       cipo;
  logic                       cipo_oe;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic                       wr_pulse;
  logic [ADDR_W-1:0]          wr_addr;
  logic [ERR_W-1:0]           err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  logic [31:0] rx;
  logic        oe_seen;
  logic        cipo_seen;

  spi_regfile_periph #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .SYNC_STAGES(2), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ncs(ncs), .sclk(sclk), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_pulse) pulse_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends nbits of 'bits' MSB first; leaves ncs low when close_frame is 0.
  task automatic spi_frame(input int nbits, input logic [31:0] bits, input bit close_frame);
    rx        = '0;
    oe_seen   = 1'b0;
    cipo_seen = 1'b0;
    ncs = 1'b0;
    wait_clk(HALF);
    for (int b = nbits - 1; b >= 0; b--) begin
      copi = bits[b];
      wait_clk(HALF);
      rx        = {rx[30:0], cipo};
      oe_seen   = oe_seen | cipo_oe;
      cipo_seen = cipo_seen | cipo;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    wait_clk(HALF);
    if (close_frame) begin
      ncs = 1'b1;
      wait_clk(10);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ncs   = 1'b1;
    sclk  = 1'b0;
    copi  = 1'b0;
    wait_clk(5);
    check_eq("rst_regs", 64'(regs_flat), 64'h0);
    check_eq("rst_cipo", 64'(cipo), 64'h0);
    check_eq("rst_oe", 64'(cipo_oe), 64'h0);
    check_eq("rst_wr_pulse", 64'(wr_pulse), 64'h0);
    check_eq("rst_wr_addr", 64'(wr_addr), 64'h0);
    check_eq("rst_err", 64'(err_cnt), 64'h0);
    rst_n = 1'b1;
    wait_clk(5);

    spi_frame(16, 32'h82A5, 1'b1);
    check_eq("wr2_regs", 64'(regs_flat), 64'h00_00_A5_00_00);
    check_eq("wr2_pulses", 64'(pulse_cnt), 64'd1);
    check_eq("wr2_addr", 64'(wr_addr), 64'd2);
    check_eq("wr2_err", 64'(err_cnt), 64'd0);

    spi_frame(16, 32'h8511, 1'b1);
    check_eq("oor_regs", 64'(regs_flat), 64'h00_00_A5_00_00);
    check_eq("oor_pulses", 64'(pulse_cnt), 64'd1);
    check_eq("oor_err", 64'(err_cnt), 64'd1);

    spi_frame(10, 32'h201, 1'b1);
    check_eq("short_err", 64'(err_cnt), 64'd2);
    spi_frame(17, 32'h100EF, 1'b1);
    check_eq("long_err", 64'(err_cnt), 64'd3);
    check_eq("long_regs", 64'(regs_flat), 64'h00_00_A5_00_00);
    check_eq("long_pulses", 64'(pulse_cnt), 64'd1);

    spi_frame(16, 32'h8077, 1'b1);
    check_eq("wr0_regs", 64'(regs_flat), 64'h00_00_A5_00_77);
    check_eq("wr0_addr", 64'(wr_addr), 64'd0);
    check_eq("wr0_err", 64'(err_cnt), 64'd3);

    spi_frame(16, 32'h813C, 1'b1);
    check_eq("wr1_regs", 64'(regs_flat), 64'h00_00_A5_3C_77);
    check_eq("wr1_pulses", 64'(pulse_cnt), 64'd3);

    spi_frame(16, 32'h0100, 1'b1);
`ifdef SPI_READBACK_EN
    check_eq("rd1_data", 64'(rx[7:0]), 64'h3C);
    check_eq("rd1_oe", 64'(oe_seen), 64'h1);
`else
    check_eq("rd1_cipo", 64'(cipo_seen), 64'h0);
    check_eq("rd1_oe", 64'(oe_seen), 64'h0);
`endif
    check_eq("rd1_err", 64'(err_cnt), 64'd3);
    check_eq("rd1_pulses", 64'(pulse_cnt), 64'd3);

    spi_frame(16, 32'h0900, 1'b1);
    check_eq("rd9_data", 64'(rx[7:0]), 64'h00);
    check_eq("rd9_err", 64'(err_cnt), 64'd3);

    spi_frame(12, 32'h84A, 1'b0);
    rst_n = 1'b0;
    wait_clk(3);
    ncs = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(10);
    check_eq("mrst_regs", 64'(regs_flat), 64'h0);
    check_eq("mrst_err", 64'(err_cnt), 64'd0);

    for (int k = 0; k < 257; k++) begin
      ncs = 1'b0;
      wait_clk(HALF);
      ncs = 1'b1;
      wait_clk(HALF);
    end
    wait_clk(5);
    check_eq("sat_err", 64'(err_cnt), 64'hFF);
    check_eq("sat_regs", 64'(regs_flat), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
